// File: rtl/cordic_act_pkg.sv
// -----------------------------------------------------------------------------
// cordic_act_pkg
//   Shared definitions for the CORDIC activation back end (tanh = sinh/cosh).
//   - state_t    : controller states IDLE / DIV / DONE
//   - FRAC_W     : fraction bits of the Q1.FRAC_W tanh result (only 15 works)
//   - DIV_ITERS  : quotient bits produced by the sequential divider
//   - SAT_POS / SAT_NEG : saturated results +32767 / -32767
//   - abs17()    : magnitude of a 17-bit two's complement value, returned as
//                  17-bit unsigned so that -65536 maps to 65536
// -----------------------------------------------------------------------------
package cordic_act_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int FRAC_W    = 15;
  localparam int DIV_ITERS = 16;

  localparam logic [15:0] SAT_POS = 16'h7FFF;
  localparam logic [15:0] SAT_NEG = 16'h8001;

  function automatic logic [16:0] abs17(input logic [16:0] v);
    return v[16] ? (~v + 17'd1) : v;
  endfunction

endpackage

// File: rtl/cordic_seq_divider.sv
// -----------------------------------------------------------------------------
// cordic_seq_divider
//   Restoring shift/subtract divider computing the 16 low quotient bits of
//   (dividend << 15) / divisor, MSB first, one bit per clock.
//   The first bit is resolved on the start edge itself, straight from the
//   input operands, so the final bit lands on the 16th edge counting the
//   start edge; done pulses for one cycle right after that edge.
//   The caller guarantees the true quotient fits in 16 bits whenever the
//   result is used (it saturates separately when dividend >= divisor).
//
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : load operands and resolve the first quotient bit
//   dividend    : 17-bit unsigned numerator magnitude (before << 15)
//   divisor     : 17-bit divisor, positive
//   busy        : iterations still outstanding
//   done        : one-cycle pulse, quotient is final
//   quotient    : 16-bit quotient, held until the next start
// -----------------------------------------------------------------------------
module cordic_seq_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [16:0] dividend,
  input  logic [16:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient
);
  import cordic_act_pkg::*;

  localparam logic [3:0] LAST_CNT = 4'(DIV_ITERS - 1);

  logic [17:0] rem_reg;
  logic [15:0] bits_reg;
  logic [16:0] dsr_reg;
  logic [15:0] quo_reg;
  logic [3:0]  cnt_reg;
  logic        busy_reg;
  logic        done_reg;

  logic [17:0] rem_in;
  logic [15:0] bits_in;
  logic [16:0] dsr_in;
  logic [17:0] trial;
  logic [17:0] diff;
  logic        take;
  logic [17:0] rem_step;
  logic [15:0] bits_step;
  logic [15:0] quo_step;

  // One restoring step. On start the partial remainder is seeded with the
  // upper 16 bits of (dividend << 15), i.e. dividend >> 1, and the one
  // remaining non-zero numerator bit (dividend[0]) is queued to shift in first.
  always_comb begin
    rem_in    = start ? {2'b00, dividend[16:1]} : rem_reg;
    bits_in   = start ? {dividend[0], 15'd0} : bits_reg;
    dsr_in    = start ? divisor : dsr_reg;
    trial     = {rem_in[16:0], bits_in[15]};
    // a set overflow bit means the shifted remainder exceeds any 17-bit divisor
    take      = rem_in[17] | (trial >= {1'b0, dsr_in});
    diff      = trial - {1'b0, dsr_in};
    rem_step  = take ? diff : trial;
    bits_step = {bits_in[14:0], 1'b0};
    quo_step  = start ? {15'd0, take} : {quo_reg[14:0], take};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_reg  <= '0;
      bits_reg <= '0;
      dsr_reg  <= '0;
      quo_reg  <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start || busy_reg) begin
        rem_reg  <= rem_step;
        bits_reg <= bits_step;
        dsr_reg  <= dsr_in;
        quo_reg  <= quo_step;
      end
      if (start) begin
        cnt_reg  <= 4'd1;
        busy_reg <= 1'b1;
      end else if (busy_reg) begin
        cnt_reg <= cnt_reg + 4'd1;
        if (cnt_reg == LAST_CNT) begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign quotient = quo_reg;

endmodule

// File: rtl/cordic_tanh_div.sv
// -----------------------------------------------------------------------------
// cordic_tanh_div
//   Turns a hyperbolic CORDIC output pair (xin = cosh term, yin = sinh term)
//   into tanh = yin / xin in signed Q1.15, via a 16-cycle sequential divide.
//   Results are saturated to +/-32767 (0x8000 is never produced) and
//   truncated toward zero. A non-positive xin flags div_err and returns a
//   saturated value signed like yin.
//
//   Timing (acceptance edge counted as edge 1):
//     xin > 0  : out_valid from edge 17
//     xin <= 0 : out_valid from edge 2
//   The result is held in DONE until out_ready; in_ready returns the cycle
//   after the result is consumed.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : input handshake (in_ready only in IDLE)
//   xin, yin            : signed 17-bit cosh / sinh terms
//   out_valid/out_ready : output handshake
//   tanh_out            : signed Q1.15 result
//   div_err             : xin <= 0, result saturated
//   sig_out             : unsigned Q0.16 sigmoid (1+tanh)/2, only when
//                         TANH_SIGMOID_EN is defined
//
// Build option
//   TANH_SIGMOID_EN : adds the sig_out port and its register.
// -----------------------------------------------------------------------------
module cordic_tanh_div #(
  parameter int FRAC_W = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [16:0]       xin,
  input  logic [16:0]       yin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FRAC_W:0]   tanh_out,
  output logic              div_err
`ifdef TANH_SIGMOID_EN
  ,
  output logic [FRAC_W:0]   sig_out
`endif
);
  import cordic_act_pkg::*;

  localparam logic [FRAC_W:0] ONE      = (FRAC_W + 1)'(1);
  localparam logic [FRAC_W:0] SIGN_BIT = {1'b1, {FRAC_W{1'b0}}};

  state_t state_reg, state_next;

  logic            rst_done_reg;
  logic            neg_reg;
  logic            err_pend_reg;
  logic            sat_reg;
  logic [FRAC_W:0] tanh_reg;
  logic            div_err_reg;
`ifdef TANH_SIGMOID_EN
  logic [FRAC_W:0] sig_reg;
`endif

  logic            accept;
  logic            x_bad;
  logic            y_neg;
  logic [16:0]     y_mag;
  logic            start;
  logic            finish;
  logic            div_busy;
  logic            div_done;
  logic [15:0]     quotient;
  logic [FRAC_W:0] q_sat;
  logic [FRAC_W:0] result;

  assign x_bad     = xin[16] | (xin == 17'd0);
  assign y_neg     = yin[16];
  assign y_mag     = abs17(yin);
  // in_ready stays low through reset and rises on the first edge after it
  assign in_ready  = (state_reg == IDLE) && rst_done_reg;
  assign accept    = in_valid && in_ready;
  assign start     = accept && !x_bad;
  assign out_valid = (state_reg == DONE);

  cordic_seq_divider u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dividend (y_mag),
    .divisor  (xin),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quotient)
  );

  // ---------------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = DIV;
      end
      DIV: begin
        // an invalid divisor skips the divide and completes one edge later
        if (err_pend_reg || (div_done && !div_busy)) state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign finish = (state_reg == DIV) && (state_next == DONE);

  // ---------------------------------------------------------------------------
  // Result formation: saturate magnitude, then apply sign. Magnitude is at
  // most 32767, so negation stays within [-32767, 0].
  // ---------------------------------------------------------------------------
  always_comb begin
    q_sat = (sat_reg || quotient[15]) ? SAT_POS : quotient;
    if (err_pend_reg) begin
      result = neg_reg ? SAT_NEG : SAT_POS;
    end else if (neg_reg) begin
      result = ~q_sat + ONE;
    end else begin
      result = q_sat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_done_reg <= 1'b0;
      neg_reg      <= 1'b0;
      err_pend_reg <= 1'b0;
      sat_reg      <= 1'b0;
      tanh_reg     <= '0;
      div_err_reg  <= 1'b0;
`ifdef TANH_SIGMOID_EN
      sig_reg      <= '0;
`endif
    end else begin
      rst_done_reg <= 1'b1;
      if (accept) begin
        neg_reg      <= y_neg;
        err_pend_reg <= x_bad;
        // |yin| >= xin means |quotient| >= 1.0, which is out of Q1.15 range
        sat_reg      <= !x_bad && (y_mag >= xin);
      end
      if (finish) begin
        tanh_reg    <= result;
        div_err_reg <= err_pend_reg;
`ifdef TANH_SIGMOID_EN
        // adding 0x8000 mod 2^16 is a flip of the top bit
        sig_reg     <= result ^ SIGN_BIT;
`endif
      end
    end
  end

  assign tanh_out = tanh_reg;
  assign div_err  = div_err_reg;
`ifdef TANH_SIGMOID_EN
  assign sig_out  = sig_reg;
`endif

endmodule

// File: tb/tb_cordic_tanh_div.sv
// -----------------------------------------------------------------------------
// tb_cordic_tanh_div
//   Self-checking bench for cordic_tanh_div: directed vector table, a
//   mid-divide reset sequence, and randomized pairs against an arithmetic
//   reference model. Latency is counted with the acceptance edge as edge 1.
//   Sigmoid checks are compiled in when TANH_SIGMOID_EN is defined.
// -----------------------------------------------------------------------------
module tb_cordic_tanh_div;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [16:0] xin = '0;
  logic [16:0] yin = '0;
  logic        in_ready;
  logic        out_valid;
  logic        div_err;
  logic [15:0] tanh_out;
`ifdef TANH_SIGMOID_EN
  logic [15:0] sig_out;
`endif

  int checks = 0;
  int errors = 0;
  int txn_no = 0;

  always #5 clk = ~clk;

  cordic_tanh_div #(.FRAC_W(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .xin       (xin),
    .yin       (yin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .tanh_out  (tanh_out),
    .div_err   (div_err)
`ifdef TANH_SIGMOID_EN
    ,
    .sig_out   (sig_out)
`endif
  );

  typedef struct {
    logic [16:0] x;
    logic [16:0] y;
    logic [15:0] t;
    logic        e;
    int          lat;
    int          hold;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: tanh = y/x in Q1.15, truncated, saturated to +/-32767.
  function automatic void ref_model(input logic [16:0] x, input logic [16:0] y,
                                    output logic [15:0] t, output logic e);
    int     xs, ys;
    longint mag, q;
    xs = $signed(x);
    ys = $signed(y);
    if (xs <= 0) begin
      e = 1'b1;
      t = (ys >= 0) ? 16'h7FFF : 16'h8001;
    end else begin
      e   = 1'b0;
      mag = (ys < 0) ? -longint'(ys) : longint'(ys);
      q   = (mag * 32768) / longint'(xs);
      if (q > 32767) q = 32767;
      t = (ys < 0) ? 16'(-q) : 16'(q);
    end
  endfunction

  task automatic wait_ready();
    int k;
    k = 0;
    while (!in_ready && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
  endtask

  task automatic run_txn(input logic [16:0] x, input logic [16:0] y,
                         input logic [15:0] exp_t, input logic exp_e,
                         input int exp_lat, input int hold);
    int k;
    logic seen;
    wait_ready();
    xin = x; yin = y; in_valid = 1'b1;
    @(posedge clk); #1;                       // acceptance edge = edge 1
    k = 1;
    seen = out_valid;
    in_valid = 1'($urandom_range(0, 1));      // noise that must be ignored
    xin = 17'($urandom); yin = 17'($urandom);
    while (!seen && k < 40) begin
      @(posedge clk); #1;
      k++;
      seen = out_valid;
      in_valid = 1'($urandom_range(0, 1));
      xin = 17'($urandom); yin = 17'($urandom);
    end
    chk("out_valid_seen", 32'(seen), 32'd1);
    chk("latency", 32'(k), 32'(exp_lat));
    chk("tanh", 32'(tanh_out), 32'(exp_t));
    chk("div_err", 32'(div_err), 32'(exp_e));
`ifdef TANH_SIGMOID_EN
    chk("sig", 32'(sig_out), 32'(exp_t ^ 16'h8000));
`endif
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_tanh", 32'(tanh_out), 32'(exp_t));
      chk("hold_err", 32'(div_err), 32'(exp_e));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      in_valid = 1'($urandom_range(0, 1));
      xin = 17'($urandom); yin = 17'($urandom);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;                       // consume edge
    out_ready = 1'b0;
    chk("out_valid_after_consume", 32'(out_valid), 32'd0);
    chk("in_ready_after_consume", 32'(in_ready), 32'd1);
    txn_no++;
    $display("txn %0d x=%05h y=%05h tanh=%04h exp=%04h err=%0b lat=%0d",
             txn_no, x, y, tanh_out, exp_t, exp_e, k);
  endtask

  initial begin
    logic [16:0] rx, ry;
    logic [15:0] rt;
    logic        re;
    int          sel, mag;

    vecs[0] = '{17'h04000, 17'h02000, 16'h4000, 1'b0, 17, 0};
    vecs[1] = '{17'h04000, 17'h1E000, 16'hC000, 1'b0, 17, 1};
    vecs[2] = '{17'h04000, 17'h04000, 16'h7FFF, 1'b0, 17, 0};
    vecs[3] = '{17'h04000, 17'h08000, 16'h7FFF, 1'b0, 17, 2};
    vecs[4] = '{17'h04000, 17'h10000, 16'h8001, 1'b0, 17, 0};
    vecs[5] = '{17'h00000, 17'h00005, 16'h7FFF, 1'b1, 2, 5};
    vecs[6] = '{17'h1FFFF, 17'h1FFFF, 16'h8001, 1'b1, 2, 0};
    vecs[7] = '{17'h00003, 17'h00001, 16'h2AAA, 1'b0, 17, 5};
    vecs[8] = '{17'h00003, 17'h1FFFF, 16'hD556, 1'b0, 17, 0};
    vecs[9] = '{17'h04000, 17'h00000, 16'h0000, 1'b0, 17, 1};

    // reset state
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_tanh", 32'(tanh_out), 32'd0);
    chk("rst_div_err", 32'(div_err), 32'd0);
`ifdef TANH_SIGMOID_EN
    chk("rst_sig", 32'(sig_out), 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    #2;
    chk("in_ready_before_first_edge", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("in_ready_first_edge", 32'(in_ready), 32'd1);

    // directed table
    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i].x, vecs[i].y, vecs[i].t, vecs[i].e, vecs[i].lat, vecs[i].hold);
    end

    // reset in the middle of a divide (tanh_out holds 0x0000 from vecs[9],
    // so run a non-zero result first to make the clear observable)
    run_txn(17'h04000, 17'h02000, 16'h4000, 1'b0, 17, 0);
    wait_ready();
    xin = 17'h04000; yin = 17'h02000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_tanh", 32'(tanh_out), 32'd0);
    chk("midrst_div_err", 32'(div_err), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("midrst_in_ready_held", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #2;
    chk("midrst_in_ready_release", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("midrst_in_ready_after_edge", 32'(in_ready), 32'd1);
    chk("midrst_out_valid_after", 32'(out_valid), 32'd0);
    run_txn(17'h04000, 17'h02000, 16'h4000, 1'b0, 17, 0);

    // randomized pairs against the reference model
    for (int r = 0; r < 40; r++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0) begin
        rx = ($urandom_range(0, 1) == 0) ? 17'd0 : 17'(32'h10000 | $urandom_range(0, 65535));
      end else if (sel < 4) begin
        rx = 17'($urandom_range(1, 1024));
      end else begin
        rx = 17'($urandom_range(1, 65535));
      end
      if (sel != 0 && $urandom_range(0, 2) != 0) begin
        mag = int'($urandom_range(0, 32'(int'(rx) - 1)));
        ry  = ($urandom_range(0, 1) == 0) ? 17'(mag) : 17'(-mag);
      end else begin
        ry = 17'($urandom_range(0, 131071));
      end
      ref_model(rx, ry, rt, re);
      run_txn(rx, ry, rt, re, re ? 2 : 17, int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cordic_tanh_div.md
CORDIC_TANH_DIV -- requirements
Module: cordic_tanh_div

Interface
REQ-001 SHALL have parameter FRAC_W, default 15, meaning fraction bits of the Q1.FRAC_W tanh result; only 15 is supported.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, meaning the upstream hyperbolic CORDIC pair is valid.
REQ-005 SHALL have port in_ready, output, 1, meaning the block can accept a pair.
REQ-006 SHALL have port xin, input, 17, meaning the signed cosh term (CORDIC Xout).
REQ-007 SHALL have port yin, input, 17, meaning the signed sinh term (CORDIC Yout).
REQ-008 SHALL have port out_valid, output, 1, meaning the result is valid.
REQ-009 SHALL have port out_ready, input, 1, meaning downstream accepts the result.
REQ-010 SHALL have port tanh_out, output, 16, meaning signed Q1.15 tanh = yin/xin.
REQ-011 SHALL have port div_err, output, 1, meaning xin<=0, so the result is invalid and saturated.
REQ-012 SHALL have port sig_out, output, 16, meaning unsigned Q0.16 sigmoid, present only with TANH_SIGMOID_EN.

Function
REQ-013 SHALL implement an FSM with states IDLE, DIV and DONE; reset enters IDLE.
REQ-014 SHALL hold in_ready=1 only in IDLE; a transfer occurs on a rising edge with in_valid&&in_ready.
REQ-015 SHALL, on a transfer, register sign(yin), |yin| as 17-bit unsigned (so -65536 gives 65536), and xin.
REQ-016 SHALL, on a transfer with xin<=0, go to DONE next edge with div_err=1 and tanh_out=0x7FFF if yin>=0, else 0x8001.
REQ-017 SHALL, on a transfer with xin>0, go to DIV and run a restoring divide of |yin|<<15 by xin, producing one quotient bit per cycle for 16 cycles (MSB first).
REQ-018 SHALL, after 16 DIV cycles, enter DONE; out_valid SHALL rise exactly 17 edges after the acceptance edge.
REQ-019 SHALL saturate the quotient q to 32767 when q>32767, including |yin|>=xin.
REQ-020 SHALL set tanh_out=q for a positive sign and -q for a negative sign; the range is symmetric [-32767,32767], and 0x8000 is never produced.
REQ-021 SHALL truncate toward zero; no rounding.
REQ-022 SHALL, in DONE, hold out_valid, tanh_out, div_err and sig_out stable until out_ready=1, then return to IDLE on that edge.
REQ-023 SHALL NOT accept a new input on the same edge the result is consumed; in_ready rises the cycle after.
REQ-024 SHALL ignore in_valid and input changes during DIV and DONE.

Reset
REQ-025 SHALL, on rst_n low at any time (including mid-DIV), asynchronously force IDLE, out_valid=0, tanh_out=0, div_err=0, sig_out=0, and clear all datapath registers.
REQ-026 SHALL, on rst_n low, force in_ready=0 while rst_n is low, and in_ready=1 from the first edge after release.

Configuration
REQ-027 SHALL, with macro TANH_SIGMOID_EN defined, provide sig_out = tanh_out + 32768 (unsigned Q0.16 of (1+tanh)/2 = sigmoid(2a)), registered with tanh_out.
REQ-028 SHALL, without TANH_SIGMOID_EN, omit the sig_out port and its logic; all other behaviour is identical.

Structure
REQ-029 SHALL place the FSM state enum (IDLE, DIV, DONE), FRAC_W, the saturation constants 0x7FFF/0x8001 and the iteration count 16 in shared package cordic_act_pkg.
REQ-030 SHALL isolate the shift/subtract iteration in sub-module cordic_seq_divider (start, busy, done, 17-bit divisor, 16-bit quotient); sign, saturation, FSM and handshake stay in cordic_tanh_div.

Verification
REQ-031 SHALL check: xin=0x04000, yin=0x02000 -> tanh_out=0x4000, div_err=0, out_valid 17 edges after accept; sig_out=0xC000 when enabled.
REQ-032 SHALL check: xin=0x04000, yin=0x1E000 (-8192) -> tanh_out=0xC000; sig_out=0x4000.
REQ-033 SHALL check: xin=0x04000, yin=0x04000, and yin=0x08000 -> tanh_out=0x7FFF both times; yin=0x10000 (-65536) -> 0x8001.
REQ-034 SHALL check: xin=0, yin=5 -> div_err=1, tanh_out=0x7FFF, out_valid on the 2nd edge after accept.
REQ-035 SHALL check: out_ready held low for 5 cycles in DONE -> outputs stable and in_ready=0; on out_ready=1, IDLE follows and in_ready=1 next cycle.
REQ-036 SHALL check: rst_n pulsed low at DIV cycle 8 -> immediate out_valid=0 and tanh_out=0; a fresh accept after release gives a correct result (REQ-031 values).
